// File: rtl/mm_pkg.sv
// Shared definitions for the code-entry game: code geometry, symbol type,
// scorer state encoding and symbol extraction.
package mm_pkg;

  localparam int SYMBOLS = 4;
  localparam int SYM_W   = 2;
  localparam int CODE_W  = SYMBOLS * SYM_W;

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXACT   = 2'd1,
    PARTIAL = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Symbol k lives in bits [k*SYM_W +: SYM_W].
  function automatic sym_t sym_at(input code_t code, input int idx);
    return code[idx*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/guess_scorer_if.sv
// Handshake bundle between the button-entry/store stage (master) and the
// guess scorer (slave).
interface guess_scorer_if;
  import mm_pkg::*;

  logic       check;
  logic       edit;
  code_t      key;
  code_t      guess;
  logic       new_game;
  logic       busy;
  logic       score_valid;
  logic [2:0] exact;
  logic [2:0] partial;
  logic [3:0] attempts;
  logic       win;
  logic       lose;

  modport master (
    output check, edit, key, guess, new_game,
    input  busy, score_valid, exact, partial, attempts, win, lose
  );

  modport slave (
    input  check, edit, key, guess, new_game,
    output busy, score_valid, exact, partial, attempts, win, lose
  );

endinterface

// File: rtl/guess_scorer_rise_detect.sv
// Registered 0->1 edge detector: rise is high in the cycle where level is 1
// and was 0 at the previous clock edge. Shared with the display stage.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/guess_scorer.sv
// Sequential guess scorer: exact pass then pairwise partial pass, one result per
// accepted check rise. Optional attempt limit under macro ATTEMPT_LIMIT_EN.
module guess_scorer #(
  parameter int SYMBOLS   = mm_pkg::SYMBOLS,
  parameter int SYM_W     = mm_pkg::SYM_W,
  parameter int MAX_TRIES = 8
) (
  input  logic           clk,
  input  logic           reset,
  guess_scorer_if.slave  bus
);
  import mm_pkg::*;

  // state   | meaning
  // IDLE    | waiting for a check rise; results held
  // EXACT   | one position compared per cycle, SYMBOLS cycles
  // PARTIAL | one (guess i, key j) pair per cycle, SYMBOLS^2 cycles
  // DONE    | publish counts, bump attempts, update win/lose

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_EXACT   = EXACT;
  localparam logic [1:0] ST_PARTIAL = PARTIAL;
  localparam logic [1:0] ST_DONE    = DONE;

  // Index split below assumes SYMBOLS is a power of two.
  localparam int IDX_W  = $clog2(SYMBOLS);
  localparam int STEP_W = 2 * IDX_W;
  localparam logic [STEP_W-1:0] EXACT_LAST = STEP_W'(SYMBOLS - 1);
  localparam logic [STEP_W-1:0] PART_LAST  = STEP_W'(SYMBOLS * SYMBOLS - 1);
  localparam logic [2:0]        FULL       = 3'(SYMBOLS);

  logic [1:0]         state;
  logic [STEP_W-1:0]  step;
  code_t              key_q;
  code_t              guess_q;
  logic [SYMBOLS-1:0] key_used;
  logic [SYMBOLS-1:0] guess_used;
  logic [2:0]         exact_cnt;
  logic [2:0]         partial_cnt;
  logic [2:0]         exact_q;
  logic [2:0]         partial_q;
  logic               score_valid_q;
  logic [3:0]         attempts_q;
  logic [3:0]         attempts_next;
  logic               win_q;
  logic               lose_q;

  logic               check_rise;
  logic               request;
  logic [IDX_W-1:0]   p_idx;
  logic [IDX_W-1:0]   g_idx;
  logic               exact_hit;
  logic               partial_hit;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .level (bus.check),
    .rise  (check_rise)
  );

  assign request = check_rise & ~bus.edit & ~win_q & ~lose_q & (state == ST_IDLE);

  // In EXACT only the low index field moves; in PARTIAL it is the key index j.
  assign p_idx = step[IDX_W-1:0];
  assign g_idx = step[STEP_W-1:IDX_W];

  assign exact_hit   = sym_at(guess_q, int'(p_idx)) == sym_at(key_q, int'(p_idx));
  assign partial_hit = !guess_used[g_idx] && !key_used[p_idx] &&
                       (sym_at(guess_q, int'(g_idx)) == sym_at(key_q, int'(p_idx)));

  assign attempts_next = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      step          <= '0;
      key_q         <= '0;
      guess_q       <= '0;
      key_used      <= '0;
      guess_used    <= '0;
      exact_cnt     <= '0;
      partial_cnt   <= '0;
      exact_q       <= '0;
      partial_q     <= '0;
      score_valid_q <= 1'b0;
      attempts_q    <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else if (bus.new_game) begin
      state         <= ST_IDLE;
      step          <= '0;
      key_used      <= '0;
      guess_used    <= '0;
      exact_cnt     <= '0;
      partial_cnt   <= '0;
      exact_q       <= '0;
      partial_q     <= '0;
      score_valid_q <= 1'b0;
      attempts_q    <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      score_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (request) begin
            key_q       <= bus.key;
            guess_q     <= bus.guess;
            key_used    <= '0;
            guess_used  <= '0;
            exact_cnt   <= '0;
            partial_cnt <= '0;
            step        <= '0;
            state       <= ST_EXACT;
          end
        end
        ST_EXACT: begin
          if (exact_hit) begin
            exact_cnt         <= exact_cnt + 3'd1;
            key_used[p_idx]   <= 1'b1;
            guess_used[p_idx] <= 1'b1;
          end
          if (step == EXACT_LAST) begin
            step  <= '0;
            state <= ST_PARTIAL;
          end else begin
            step  <= step + STEP_W'(1);
          end
        end
        ST_PARTIAL: begin
          if (partial_hit) begin
            partial_cnt       <= partial_cnt + 3'd1;
            key_used[p_idx]   <= 1'b1;
            guess_used[g_idx] <= 1'b1;
          end
          if (step == PART_LAST) begin
            step  <= '0;
            state <= ST_DONE;
          end else begin
            step  <= step + STEP_W'(1);
          end
        end
        ST_DONE: begin
          exact_q       <= exact_cnt;
          partial_q     <= partial_cnt;
          score_valid_q <= 1'b1;
          attempts_q    <= attempts_next;
          if (exact_cnt == FULL) win_q <= 1'b1;
`ifdef ATTEMPT_LIMIT_EN
          else if (attempts_next == 4'(MAX_TRIES)) lose_q <= 1'b1;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef ATTEMPT_LIMIT_EN
  logic unused_max_tries;
  assign unused_max_tries = ^(4'(MAX_TRIES));
`endif

  assign bus.busy        = (state != ST_IDLE);
  assign bus.score_valid = score_valid_q;
  assign bus.exact       = exact_q;
  assign bus.partial     = partial_q;
  assign bus.attempts    = attempts_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;

endmodule

// File: doc/guess_scorer.md
# guess_scorer

Scores each guess against the programmed key for the code-entry game. Sits directly downstream of the button-entry/store stage. On the rising edge of that stage's `check` flag it latches `key` and `guess`, computes exact-position and colour-only matches sequentially, and reports one scored result per guess. It also keeps the per-game attempt count and the win/lose flags that feed the display.

## Interface

Parameters:
- `SYMBOLS`, 4: symbols per code.
- `SYM_W`, 2: bits per symbol; symbol k occupies bits [k*SYM_W+SYM_W-1 : k*SYM_W].
- `MAX_TRIES`, 8: attempt limit (used only with `ATTEMPT_LIMIT_EN`).

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state.
- `check`, in, 1: level from store stage; a scoring request is a 0→1 transition.
- `edit`, in, 1: high while the key is being programmed; check rises with `edit`=1 are ignored.
- `key`, in, SYMBOLS*SYM_W: programmed code.
- `guess`, in, SYMBOLS*SYM_W: entered guess.
- `new_game`, in, 1: synchronous clear of game state; aborts any scoring in progress.
- `busy`, out, 1: high while scoring.
- `score_valid`, out, 1: one-cycle pulse when `exact`/`partial` update.
- `exact`, out, 3: symbols correct in value and position.
- `partial`, out, 3: symbols correct in value, wrong position.
- `attempts`, out, 4: guesses scored this game, saturating at 15.
- `win`, out, 1: sticky; set when `exact`==SYMBOLS.
- `lose`, out, 1: sticky; constant 0 without `ATTEMPT_LIMIT_EN`.

## Operation

- Reset value of every output and register: 0; state IDLE.
- Rise detection: register `check_d`. A request is `check & ~check_d & ~edit` sampled in IDLE with `win`=`lose`=0. Rises in any other state or condition are dropped, not queued.
- State machine IDLE → EXACT → PARTIAL → DONE → IDLE.
- IDLE: on request, latch `key`/`guess` into local copies, clear working counters and the used-masks `key_used`/`guess_used`, go to EXACT.
- EXACT (SYMBOLS cycles, index p = 0..3): if `g[p]==k[p]`, increment the exact count and set `key_used[p]` and `guess_used[p]`.
- PARTIAL (SYMBOLS² = 16 cycles, guess index i outer, key index j inner, both 0..3): if `!guess_used[i] && !key_used[j] && g[i]==k[j]`, increment the partial count and set both used bits. Cycle count is fixed regardless of data.
- DONE (1 cycle):
  - copy the counts to `exact`/`partial` and pulse `score_valid`;
  - `attempts` += 1, saturating at 15;
  - `win` set if exact==SYMBOLS;
  - return to IDLE.
- Counts are 3 bits; the maximum value is 4. `exact + partial` ≤ SYMBOLS always.
- `new_game`: from any state, next state IDLE. Clears `attempts`, `win`, `lose`, `exact`, `partial`, working counters and masks. No `score_valid` for an aborted score. Wins over a simultaneous request.
- `busy` = state ≠ IDLE.
- Inputs `key`/`guess` may change freely after the latch cycle.

## Timing

- Edge E samples the request. Outputs update and `score_valid` goes high at edge E+21 (after 4 EXACT + 16 PARTIAL cycles); `score_valid` falls at E+22.
- `busy` is high from E+1 through the DONE cycle and low after E+22.
- Earliest next accepted request: the edge E+22.
- `exact`/`partial` hold until the next DONE, `new_game` or reset.
- `reset` asserted mid-score: immediate clear, no pulse. Operation restarts on the first request after release.

## Configuration

- `ATTEMPT_LIMIT_EN` defined:
  - in DONE, if not winning and the new `attempts`==MAX_TRIES, set `lose`;
  - win takes priority when both apply;
  - further requests are ignored until `new_game`.
- Not defined:
  - `lose` is tied to 0;
  - `attempts` just saturates;
  - play is unlimited until a win.

## Structure

- Shared package `mm_pkg`: `SYMBOLS`, `SYM_W`, `sym_t` typedef, the state enum (IDLE/EXACT/PARTIAL/DONE), and a `sym_at(code, idx)` extraction function.
- One sub-module: `rise_detect` (registered 0→1 pulse on `check`, async active-low reset). It is reused by the display stage.

## Test plan

- key=8'hE4, guess=8'hE4, check rise → 21 cycles later `score_valid` pulse, exact=4, partial=0, win=1, attempts=1.
- key=8'hE4, guess=8'h1B → exact=0, partial=4, win=0.
- Duplicates: key=8'h05, guess=8'h00 → exact=2, partial=0. Then key=8'h05, guess=8'h50 → exact=0, partial=4.
- Check rise with edit=1 → no busy, no pulse. Second check rise while busy → ignored; exactly one `score_valid`. `new_game` at E+10 → busy drops, no pulse, attempts=0.
- `reset` low mid-PARTIAL → all outputs 0 immediately. After release, key=8'hE4, guess=8'hE0 → exact=3, partial=0.
- `ATTEMPT_LIMIT_EN`, MAX_TRIES=2: two non-matching guesses → lose=1 with the second pulse; third check rise ignored. Without the macro: 16 wrong guesses → attempts=15, lose=0.
